lsu_rmw: RTL and testbench
==========================

// Module: lsu_rmw
// PURPOSE
//  Load/store unit between the single-cycle core's execute stage and the word-only, byte-array data memory.
//  - Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned memory accesses; read and write are never enabled together.
//  - Sub-word stores use a two-cycle read-modify-write, and the core is stalled for one cycle.
//  - Flags misaligned and out-of-range accesses instead of issuing them.
// PARAMETERS
//  DEPTH    1024  data memory size in bytes; word accesses require addr <= DEPTH-4
//  RESET_PC unused here; deliberately absent (no PC coupling)
// PORTS
//  clk              in   1   rising-edge clock
//  rst              in   1   asynchronous, active-high reset
//  req_valid        in   1   core has a memory op this cycle
//  req_write        in   1   1=store, 0=load
//  req_funct3       in   3   RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr         in   32  byte address (rs1+imm)
//  req_wdata        in   32  store data (rs2)
//  stall            out  1   core must hold PC and request stable this cycle
//  load_data        out  32  extended load result, valid when load_valid
//  load_valid       out  1   load completed this cycle
//  misalign_exc     out  1   request rejected: misaligned
//  range_exc        out  1   request rejected: word outside 0..DEPTH-4
//  mem_addr         out  32  word-aligned address {req_addr[31:2],2'b00}
//  mem_write_value  out  32  word to write
//  mem_write_enable out  1
//  mem_read_enable  out  1
//  mem_read_value   in   32  combinational read data, same cycle
// BEHAVIOUR
//  - Reset (async, while rst=1): state=IDLE; merge register=0.
//    All outputs are 0: stall, enables, exc flags, load_valid, load_data.
//    Reset during MERGE_WR aborts it; no write is issued.
//  - Checks:
//    misaligned = H/HU with addr[0]; W with addr[1:0]!=0.
//    out of range = aligned word address > DEPTH-4.
//    Either check failing: exc flag =1 for that cycle, enables 0, stall 0, load_valid 0. misalign_exc takes priority.
//  - IDLE, load: mem_read_enable=1 and load_valid=1 combinationally.
//    - Lane = addr[1:0] (byte) or addr[1] (half).
//    - B/H sign-extend; BU/HU zero-extend; W is passthrough. Latency 0, no stall.
//  - IDLE, SW: mem_write_enable=1, mem_write_value=req_wdata; single cycle, no stall.
//  - IDLE, SB/SH: mem_read_enable=1 and stall=1.
//    - Latch mem_read_value with the selected lane(s) replaced by req_wdata[7:0] / [15:0]. Next state MERGE_WR.
//  - MERGE_WR: mem_write_enable=1, mem_write_value=merge register, stall=0; the held request is consumed; next IDLE.
//    - req_* are ignored except req_addr, which drives mem_addr and must equal the latched value.
//  - req_valid=0 in IDLE: no enables, no flags; state stays IDLE.
//  - Invalid funct3 (011, 110, 111): treated as misaligned (misalign_exc=1), no access.
//  - States: IDLE -> MERGE_WR (aligned, in-range SB/SH) -> IDLE. No other transitions.
// CONFIGURATION
//  LSU_ACCESS_COUNT_EN
//  - Defined: adds outputs cnt_load, cnt_store, cnt_rmw (32 bits each, wrapping).
//    - Each increments once per completed op: cnt_rmw and cnt_store both advance on the MERGE_WR cycle; cnt_load on load_valid.
//    - Cleared by rst.
//  - Undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  lsu_pkg:
//  - FUNCT3_* localparams.
//  - State encoding IDLE=1'b0, MERGE_WR=1'b1.
//  - Helper function lsu_is_aligned(funct3, addr[1:0]).
//  Sub-module lsu_lane_align (purely combinational):
//  - Load extract/extend.
//  - Store lane merge.
//  lsu_rmw holds the FSM, the merge register, and the checks.
// TESTING
//  - Mem word @0x10 = 0x8899AABB:
//    - LB 0x11 -> 0xFFFFFFAA.
//    - LBU 0x11 -> 0x000000AA.
//    - LH 0x12 -> 0xFFFF8899.
//    - LW 0x10 -> 0x8899AABB. All same cycle, stall=0.
//  - SB 0x13 wdata 0x12345677:
//    - Cycle 1: read_en=1, stall=1.
//    - Cycle 2: write_en=1, value 0x7799AABB, stall=0.
//    - Read-back LW -> 0x7799AABB.
//  - SW 0x20 data 0xDEADBEEF: one write cycle, no stall. LW 0x20 -> 0xDEADBEEF.
//  - LW 0x22, SH 0x21: misalign_exc=1, no enables. LW 0x3FC ok; LW 0x400 (DEPTH=1024) -> range_exc=1.
//  - Assert rst during MERGE_WR of SH 0x30: no write; mem@0x30 unchanged; all outputs 0; next op starts in IDLE.
//  - Throughout, enforce read_enable && write_enable == 0 and aligned mem_addr every cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the alignment rule used by the request checks.
package lsu_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } state_e;

  // Unknown funct3 codes report as misaligned so they never reach memory.
  function automatic logic lsu_is_aligned(input logic [2:0] funct3, input logic [1:0] addr);
    logic ok;
    case (funct3)
      FUNCT3_B, FUNCT3_BU: ok = 1'b1;
      FUNCT3_H, FUNCT3_HU: ok = ~addr[0];
      FUNCT3_W:            ok = (addr == 2'b00);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: extracts and extends load data, and merges store
// data into a read word for sub-word read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      FUNCT3_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_BU: load_data_o = {24'd0, byte_sel};
      FUNCT3_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
      FUNCT3_HU: load_data_o = {16'd0, half_sel};
      default:   load_data_o = rdata_i;
    endcase
  end

  // Store merge: only B and H reach here through the RMW path.
  always_comb begin
    merge_data_o = rdata_i;
    if (funct3_i == FUNCT3_B) begin
      case (lane_i)
        2'd0: merge_data_o[7:0]   = wdata_i[7:0];
        2'd1: merge_data_o[15:8]  = wdata_i[7:0];
        2'd2: merge_data_o[23:16] = wdata_i[7:0];
        2'd3: merge_data_o[31:24] = wdata_i[7:0];
        default: merge_data_o = rdata_i;
      endcase
    end else if (lane_i[1]) begin
      merge_data_o[31:16] = wdata_i[15:0];
    end else begin
      merge_data_o[15:0] = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit with two-cycle read-modify-write for SB/SH.
// Optional access counters are enabled with `define LSU_ACCESS_COUNT_EN.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_exc,
  output logic        range_exc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_value,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_value
`ifdef LSU_ACCESS_COUNT_EN
  ,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_store,
  output logic [31:0] cnt_rmw
`endif
);

  localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] word_addr;
  logic [31:0] ext_data;
  logic [31:0] merged;
  logic        misaligned;
  logic        out_of_range;

  assign word_addr    = {req_addr[31:2], 2'b00};
  // Stores only have B/H/W encodings; anything else is rejected as misaligned.
  assign misaligned   = (req_write & req_funct3[2]) | ~lsu_is_aligned(req_funct3, req_addr[1:0]);
  assign out_of_range = word_addr > LAST_WORD;

  lsu_lane_align u_align (
    .funct3_i     (req_funct3),
    .lane_i       (req_addr[1:0]),
    .rdata_i      (mem_read_value),
    .wdata_i      (req_wdata),
    .load_data_o  (ext_data),
    .merge_data_o (merged)
  );

  // Next state and combinational memory-side outputs; all forced low in reset.
  always_comb begin
    state_d          = state_q;
    merge_d          = merge_q;
    stall            = 1'b0;
    load_data        = '0;
    load_valid       = 1'b0;
    misalign_exc     = 1'b0;
    range_exc        = 1'b0;
    mem_addr         = '0;
    mem_write_value  = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (!rst) begin
      mem_addr = word_addr;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              misalign_exc = 1'b1;
            end else if (out_of_range) begin
              range_exc = 1'b1;
            end else if (!req_write) begin
              mem_read_enable = 1'b1;
              load_valid      = 1'b1;
              load_data       = ext_data;
            end else if (req_funct3 == FUNCT3_W) begin
              mem_write_enable = 1'b1;
              mem_write_value  = req_wdata;
            end else begin
              mem_read_enable = 1'b1;
              stall           = 1'b1;
              merge_d         = merged;
              state_d         = MERGE_WR;
            end
          end
        end
        MERGE_WR: begin
          mem_write_enable = 1'b1;
          mem_write_value  = merge_q;
          state_d          = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

`ifdef LSU_ACCESS_COUNT_EN
  logic [31:0] cnt_load_q, cnt_store_q, cnt_rmw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_rmw_q   <= '0;
    end else begin
      cnt_load_q  <= cnt_load_q + 32'(load_valid);
      cnt_store_q <= cnt_store_q + 32'(mem_write_enable);
      cnt_rmw_q   <= cnt_rmw_q + 32'(state_q == MERGE_WR);
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_rmw   = cnt_rmw_q;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: byte-array reference memory model plus
// directed and randomized load/store traffic.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall, load_valid, misalign_exc, range_exc;
  logic        mem_write_enable, mem_read_enable;
  logic [31:0] load_data, mem_addr, mem_write_value, mem_read_value;

  logic [31:0] env_mem [256];
  logic [7:0]  ref_mem [1024];
  int          n_cmp = 0;
  int          n_fail = 0;

  lsu_rmw #(.DEPTH(1024)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .stall            (stall),
    .load_data        (load_data),
    .load_valid       (load_valid),
    .misalign_exc     (misalign_exc),
    .range_exc        (range_exc),
    .mem_addr         (mem_addr),
    .mem_write_value  (mem_write_value),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_value   (mem_read_value)
  );

  always #5 clk = ~clk;

  assign mem_read_value = env_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write_enable) env_mem[mem_addr[9:2]] <= mem_write_value;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory-port invariants, every cycle.
  always @(negedge clk) begin
    chk("rw_exclusive", 32'(mem_read_enable & mem_write_enable), 32'd0);
    chk("addr_aligned", 32'(mem_addr[1:0]), 32'd0);
  end

  function automatic logic [31:0] ref_word(input int base);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = 32'(ref_mem[a]);
        if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        v = 32'(ref_mem[a]) + 32'd256 * 32'(ref_mem[a+1]);
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = ref_word(a);
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] f3, input int a, input logic [31:0] wd);
    logic [7:0] b [4];
    int base = a - (a % 4);
    for (int i = 0; i < 4; i++) b[i] = ref_mem[base+i];
    b[a%4] = wd[7:0];
    if (f3 == 3'd1) b[a%4+1] = wd[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic commit_word(input int base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[base+i] = w[8*i +: 8];
  endtask

  task automatic run_op(input bit w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit abort, output logic [31:0] got);
    bit legal, mis, rng;
    int a, base;
    logic [31:0] exp_w;
    legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = !legal || ((f3 inside {3'd1, 3'd5}) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
    rng   = !mis && ((addr & ~32'd3) > 32'd1020);
    a     = int'(addr[9:0]);
    base  = a - (a % 4);
    got   = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("misalign_exc", 32'(misalign_exc), 32'(mis));
    chk("range_exc", 32'(range_exc), 32'(rng));
    chk("mem_addr", mem_addr, addr & ~32'd3);
    if (mis || rng) begin
      chk("rej_enables", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
      chk("rej_stall_lv", {30'd0, stall, load_valid}, 32'd0);
    end else if (!w) begin
      chk("ld_ctrl", {29'd0, mem_read_enable, mem_write_enable, stall}, 32'b100);
      chk("ld_valid", 32'(load_valid), 32'd1);
      chk("ld_data", load_data, model_load(f3, a));
      got = load_data;
    end else if (f3 == 3'd2) begin
      chk("sw_ctrl", {29'd0, mem_read_enable, mem_write_enable, stall}, 32'b010);
      chk("sw_value", mem_write_value, wd);
      commit_word(base, wd);
    end else begin
      chk("rmw1_ctrl", {29'd0, mem_read_enable, mem_write_enable, stall}, 32'b101);
      exp_w = model_merge(f3, a, wd);
      @(posedge clk); #1;
      if (abort) begin
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {26'd0, stall, load_valid, misalign_exc, range_exc,
                           mem_read_enable, mem_write_enable}, 32'd0);
        chk("abort_ld", load_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        chk("abort_mem", env_mem[base/4], ref_word(base));
        return;
      end
      @(negedge clk);
      chk("rmw2_ctrl", {28'd0, mem_read_enable, mem_write_enable, stall, load_valid}, 32'b0100);
      chk("rmw2_value", mem_write_value, exp_w);
      commit_word(base, exp_w);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!mis && !rng) chk("mem_word", env_mem[base/4], ref_word(base));
  endtask

  initial begin
    logic [31:0] got, r;
    logic [2:0]  f3_pool [7];
    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      if (i == 4)  r = 32'h8899AABB;
      if (i == 12) r = 32'h01234567;
      env_mem[i] = r;
      commit_word(i * 4, r);
    end

    // Reset: outputs stay low even with a valid request presented.
    req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10;
    #3;
    chk("rst_ctrl", {26'd0, stall, load_valid, misalign_exc, range_exc,
                     mem_read_enable, mem_write_enable}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;

    run_op(0, 3'd0, 32'h11, 0, 0, got); chk("lit_lb", got, 32'hFFFFFFAA);
    run_op(0, 3'd4, 32'h11, 0, 0, got); chk("lit_lbu", got, 32'h000000AA);
    run_op(0, 3'd1, 32'h12, 0, 0, got); chk("lit_lh", got, 32'hFFFF8899);
    run_op(0, 3'd2, 32'h10, 0, 0, got); chk("lit_lw", got, 32'h8899AABB);
    run_op(1, 3'd0, 32'h13, 32'h12345677, 0, got);
    chk("lit_sb_mem", env_mem[4], 32'h7799AABB);
    run_op(0, 3'd2, 32'h10, 0, 0, got); chk("lit_lw_sb", got, 32'h7799AABB);
    run_op(1, 3'd2, 32'h20, 32'hDEADBEEF, 0, got);
    run_op(0, 3'd2, 32'h20, 0, 0, got); chk("lit_lw_sw", got, 32'hDEADBEEF);
    run_op(0, 3'd2, 32'h22, 0, 0, got);
    run_op(1, 3'd1, 32'h21, 32'h5555, 0, got);
    run_op(0, 3'd2, 32'h3FC, 0, 0, got);
    run_op(0, 3'd2, 32'h400, 0, 0, got);
    run_op(0, 3'd7, 32'h40, 0, 0, got);
    run_op(1, 3'd1, 32'h30, 32'hCAFEF00D, 1, got);
    run_op(0, 3'd2, 32'h30, 0, 0, got); chk("lit_after_abort", got, 32'h01234567);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      logic [2:0]  f3;
      bit          w;
      w    = 1'($urandom % 2);
      f3   = f3_pool[$urandom % (($urandom % 8 == 0) ? 7 : 5)];
      addr = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 1100));
      run_op(w, f3, addr, $urandom, 0, got);
      if ($urandom % 4 == 0) @(posedge clk);
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
